seg_scan_capture: RTL
=====================

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 16: the number of consecutive identical synchronized samples (minimum 2) required to accept a digit.
REQ-002 The module SHALL have port clk, input, 1: the single clock for all state.
REQ-003 The module SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 The module SHALL have port an, input, 8: active-low digit anodes from a multiplexed seven-segment driver.
REQ-005 The module SHALL have port c, input, 7: active-low cathodes, where c[0]=a through c[6]=g.
REQ-006 The module SHALL have port clear, input, 1: a synchronous one-cycle request that clears the sticky errors and the frame-progress state.
REQ-007 The module SHALL have port digits, output, 32: the last captured nibble per anode, where digit k is at digits[4k+3:4k].
REQ-008 The module SHALL have port bcd, output, 12: {digit2, digit1, digit0}, snapshotted at frame completion.
REQ-009 The module SHALL have port frame_valid, output, 1: a one-cycle pulse when all 8 digits have been captured.
REQ-010 The module SHALL have port pattern_err, output, 1: sticky; set when a non-decimal cathode pattern is captured.
REQ-011 The module SHALL have port anode_err, output, 1: sticky; set when more than one anode is low in a stable sample.

Function
REQ-012 The module SHALL pass an and c through a 2-flop synchronizer before any other use.
REQ-013 The module SHALL hold a stability counter that increments, saturating at STABLE_CYCLES-1, while the synchronized {an,c} equals the previous cycle's value, and that loads 0 on any difference.
REQ-014 A capture strobe SHALL assert for exactly one cycle when the counter first reaches STABLE_CYCLES-1; no further strobe SHALL occur until the sample changes.
REQ-015 For pins that change before edge E0 and then hold, the digit register SHALL update at edge E(STABLE_CYCLES+2).
REQ-016 On a strobe with exactly one an bit low (index k), the module SHALL write the decoded nibble to digit k and set seen[k].
REQ-017 The module SHALL decode c as follows: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
REQ-018 On a strobe with any other c pattern, the module SHALL write 4'hF to digit k, set seen[k], and set pattern_err.
REQ-019 On a strobe with an = 8'hFF (blanking), the module SHALL take no action.
REQ-020 On a strobe with two or more an bits low, the module SHALL set anode_err and leave no digit or seen bit modified.
REQ-021 When seen becomes 8'hFF, the module SHALL pulse frame_valid on the following cycle, load bcd from the current digit2..digit0, and clear seen.
REQ-022 Recapture of an already-seen digit before frame completion SHALL overwrite that digit and leave seen unchanged.
REQ-023 clear SHALL zero pattern_err, anode_err and seen, and SHALL suppress a capture in the same cycle (clear wins).
REQ-024 The module SHALL have no handshake; frame_valid SHALL be informational and not held.

Reset
REQ-025 Reset SHALL set the synchronizer and previous-sample registers to all ones (blank), the counter to 0, seen to 0, digits to 0, bcd to 0, frame_valid to 0, pattern_err to 0 and anode_err to 0.
REQ-026 Reset asserted mid-dwell SHALL discard the partial count; after release, a full STABLE_CYCLES dwell SHALL be required before any capture.

Structure
REQ-027 The cathode encoding constants, the blank pattern 8'hFF and the invalid nibble 4'hF SHALL live in a shared seven_seg package used by both the display driver and this block.
REQ-028 The cathode-to-nibble decode SHALL be a combinational sub-module, seg_decode (c in; nibble and valid out).
REQ-029 The counter width SHALL be $clog2(STABLE_CYCLES).

Verification
REQ-030 The bench SHALL drive an=11111110, c=0100100 held for 20 cycles with STABLE_CYCLES=16 -> digits[3:0]=2 at edge 18, exactly one strobe, no errors.
REQ-031 The bench SHALL scan digits 0..7 with values 3,0,7,0,0,0,0,0 at 32 cycles each -> a single frame_valid pulse after digit 7, bcd=12'h703, seen cleared.
REQ-032 The bench SHALL toggle c every 10 cycles for 200 cycles -> no capture and digits unchanged.
REQ-033 The bench SHALL hold an=11111100 stable -> anode_err=1, digits and seen unchanged; then pulse clear -> anode_err=0.
REQ-034 The bench SHALL hold an=11111011 with c=1111111 -> digit2=F and pattern_err=1 (sticky across later valid digits).
REQ-035 The bench SHALL assert reset at count 10 of a dwell -> all outputs 0 at once; after release, a capture SHALL occur only after a new 16-cycle dwell.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: cathode codes and sentinels shared by the seven-segment driver and capture logic
package seven_seg_pkg;
    localparam logic [7:0] AN_BLANK       = 8'hFF;
    localparam logic [3:0] NIBBLE_INVALID = 4'hF;
    localparam logic [6:0] SEG_CODE [10]  = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
endpackage

// File: rtl/seg_decode.sv
// seg_decode: active-low cathodes (c[0]=a..c[6]=g) to decimal nibble; valid=0 and nibble=F otherwise
module seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] c,
    output logic [3:0] nibble,
    output logic       valid
);
    always_comb begin
        nibble = NIBBLE_INVALID;
        valid  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (c == SEG_CODE[i]) begin
                nibble = 4'(i);
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: snoops a multiplexed 7-seg bus, captures stable digits, reports frames and errors
// Ports: clk, reset (async high); an/c active-low pins; clear wipes errors and frame progress;
// digits (nibble k at [4k+3:4k]), bcd snapshot of digits 2..0, frame_valid pulse, sticky errors.
module seg_scan_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  an,
    input  logic [6:0]  c,
    input  logic        clear,
    output logic [31:0] digits,
    output logic [11:0] bcd,
    output logic        frame_valid,
    output logic        pattern_err,
    output logic        anode_err
);
    localparam int              CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [14:0]   s1, s2, prev;
    logic [CW-1:0] cnt;
    logic          hold;
    logic [7:0]    seen;
    logic [7:0]    an_low;
    logic          strobe;
    logic [3:0]    nibble;
    logic          valid;

    seg_decode u_dec (.c(prev[6:0]), .nibble(nibble), .valid(valid));

    // prev holds the sample that the counter has been qualifying, so it is what gets decoded
    always_comb begin
        an_low = ~prev[14:7];
        strobe = (cnt == CNT_MAX) && !hold;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1          <= '1;
            s2          <= '1;
            prev        <= '1;
            cnt         <= '0;
            hold        <= 1'b0;
            seen        <= '0;
            digits      <= '0;
            bcd         <= '0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            s1          <= {an, c};
            s2          <= s1;
            prev        <= s2;
            cnt         <= (s2 != prev) ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            // hold blocks repeat strobes while the counter sits saturated
            hold        <= (cnt == CNT_MAX);
            frame_valid <= 1'b0;
            if (clear) begin
                seen        <= '0;
                pattern_err <= 1'b0;
                anode_err   <= 1'b0;
            end else if (seen == 8'hFF) begin
                frame_valid <= 1'b1;
                bcd         <= digits[11:0];
                seen        <= '0;
            end else if (strobe && prev[14:7] != AN_BLANK) begin
                if ($onehot(an_low)) begin
                    for (int k = 0; k < 8; k++)
                        if (an_low[k]) digits[4*k +: 4] <= nibble;
                    seen <= seen | an_low;
                    if (!valid) pattern_err <= 1'b1;
                end else begin
                    anode_err <= 1'b1;
                end
            end
        end
    end
endmodule
